instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Inverse of the main decoder: packs field-level instruction requests (class, regs, funct, imm)
//  into 32-bit RV32I/F words and writes them sequentially into instruction memory.
//  Used as the program loader / test-stream generator in front of the pipeline's imem.
//  Clock `clk`; reset `reset` is asynchronous and active-low (reset==0 resets).
// PARAMETERS
//  AW         10  byte-address width of mem_addr; must be >=3
//  RESET_ADDR 0   byte address of first write after reset; must be word-aligned
// PORTS
//  clk         in   1   clock
//  reset       in   1   async active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   encoder can accept (high only in IDLE)
//  req_class   in   4   0 NOP,1 LW,2 FLW,3 SW,4 FSW,5 RTYPE,6 FPR,7 BEQ,8 ITYPE,9 JAL; 10-15 illegal
//  req_rd      in   5   destination reg
//  req_rs1     in   5   source reg 1
//  req_rs2     in   5   source reg 2
//  req_funct3  in   3   funct3 (RTYPE/FPR/ITYPE only)
//  req_funct7  in   7   funct7 (RTYPE/FPR only)
//  req_imm     in   32  sign-extended byte immediate/offset
//  mem_we      out  1   write strobe, held until mem_ack
//  mem_addr    out  AW  byte address of current write
//  mem_wdata   out  32  encoded instruction word
//  mem_ack     in   1   memory accepted write this cycle
//  err         out  1   sticky: illegal class or misaligned branch/jump offset
//  err_clr     in   1   clears err
//  count       out  16  words written since reset, wraps mod 2^16
// BEHAVIOUR
//  Reset: req_ready=0 for the reset cycle, then 1; mem_we=0, mem_addr=RESET_ADDR, mem_wdata=0,
//   err=0, count=0, state=IDLE. Reset mid-WRITE aborts: mem_we drops asynchronously, no count++.
//  FSM IDLE->WRITE on req_valid&&req_ready with legal request; word encoded combinationally and
//   registered into mem_wdata on that edge; mem_we=1 from next cycle (latency 1).
//  WRITE: mem_we, mem_addr, mem_wdata stable until mem_ack; on mem_ack edge: mem_we=0,
//   mem_addr+=4 (wraps to 0 mod 2^AW), count++, ->IDLE. Next accept possible the cycle after.
//  mem_ack outside WRITE ignored. Illegal request: consumed (handshake completes), err=1,
//   no write, addr/count unchanged, stays IDLE. err_clr and new error same cycle: err=1.
//  Encoding (opcode / funct3 forced):
//   NOP   0x00000013 (addi x0,x0,0); all fields ignored
//   LW  0000011 f3=010, FLW 0000111 f3=010: I-fmt imm[11:0]->[31:20], rs1, rd
//   SW  0100011 f3=010, FSW 0100111 f3=010: S-fmt imm[11:5]->[31:25], imm[4:0]->[11:7], rs2, rs1
//   RTYPE 0110011, FPR 1010011: funct7->[31:25], rs2, rs1, funct3, rd
//   ITYPE 0010011: imm[11:0]->[31:20], rs1, funct3, rd (imm used verbatim)
//   BEQ 1100011 f3=000: [31]=imm[12],[30:25]=imm[10:5],[11:8]=imm[4:1],[7]=imm[11]
//   JAL 1101111: [31]=imm[20],[30:21]=imm[10:1],[20]=imm[11],[19:12]=imm[19:12], rd
//  BEQ/JAL with req_imm[0]=1: illegal (err). Upper imm bits beyond field width dropped silently.
// CONFIGURATION
//  INSTR_ENCODER_FP_EN defined: classes FLW, FSW, FPR encoded as above.
//  Not defined: classes 2, 4, 6 treated as illegal (err=1, no write); all else unchanged.
// TESTING
//  1 LW rd=5 rs1=2 imm=8 -> one cycle later mem_we=1, mem_wdata=0x00812283, mem_addr=0;
//    ack -> mem_addr=4, count=1
//  2 SW rs2=6 rs1=2 imm=12 -> 0x00612623; JAL rd=1 imm=16 -> 0x010000EF;
//    BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3
//  3 class=4'hC, then BEQ imm=3 -> err=1 both, mem_we never high, addr/count unchanged;
//    err_clr -> err=0
//  4 mem_ack delayed 3 cycles -> mem_we/addr/wdata stable, req_ready=0 throughout;
//    back-to-back reqs write addrs 0,4,8
//  5 reset low during WRITE -> mem_we=0 immediately, addr=RESET_ADDR, count=0; AW=3, 3 writes
//    -> addrs 0,4,0 (wrap)
//  6 FLW rd=1 rs1=2 imm=4 -> 0x00412087 with INSTR_ENCODER_FP_EN; err=1 and no write without it

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level instruction requests into RV32I/F words and
// writes them one at a time into instruction memory via a we/ack handshake.
// Optional feature macro: INSTR_ENCODER_FP_EN. When it is defined, the FLW, FSW
// and FPR classes are encoded. When it is undefined, those classes are rejected
// as illegal.
module instr_encoder #(
    parameter int AW         = 10,
    parameter int RESET_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_class,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rs1,
    input  logic [4:0]    req_rs2,
    input  logic [2:0]    req_funct3,
    input  logic [6:0]    req_funct7,
    input  logic [31:0]   req_imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic          err,
    input  logic          err_clr,
    output logic [15:0]   count
);

`ifdef INSTR_ENCODER_FP_EN
    localparam bit FP_EN = 1'b1;
`else
    localparam bit FP_EN = 1'b0;
`endif

    localparam logic [3:0] CL_NOP   = 4'd0;
    localparam logic [3:0] CL_LW    = 4'd1;
    localparam logic [3:0] CL_FLW   = 4'd2;
    localparam logic [3:0] CL_SW    = 4'd3;
    localparam logic [3:0] CL_FSW   = 4'd4;
    localparam logic [3:0] CL_RTYPE = 4'd5;
    localparam logic [3:0] CL_FPR   = 4'd6;
    localparam logic [3:0] CL_BEQ   = 4'd7;
    localparam logic [3:0] CL_ITYPE = 4'd8;
    localparam logic [3:0] CL_JAL   = 4'd9;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } stateT;

    stateT state, nextState;

    logic        readyQ;
    logic        vld_p0;
    logic        legal_p0;
    logic [31:0] encWord_p0;
    logic        unusedImmHi;

    // A request is legal when its class exists in this build. Branch and jump
    // offsets must also be even, because bit 0 has no slot in the B/J formats.
    function automatic logic isLegal(input logic [3:0] cls, input logic imm0);
        logic ok;
        ok = (cls <= CL_JAL);
        if (!FP_EN && (cls == CL_FLW || cls == CL_FSW || cls == CL_FPR))
            ok = 1'b0;
        if ((cls == CL_BEQ || cls == CL_JAL) && imm0)
            ok = 1'b0;
        return ok;
    endfunction

    // Builds the 32-bit instruction word. The opcode is fixed by the class, and
    // so is funct3 wherever the class implies one. Immediate bits that do not
    // fit in the format are dropped.
    function automatic logic [31:0] encodeWord(
        input logic [3:0]  cls,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [20:0] imm
    );
        logic [31:0] w;
        case (cls)
            CL_LW:    w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            CL_FLW:   w = {imm[11:0], rs1, 3'b010, rd, 7'b0000111};
            CL_SW:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            CL_FSW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100111};
            CL_RTYPE: w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            CL_FPR:   w = {f7, rs2, rs1, f3, rd, 7'b1010011};
            CL_BEQ:   w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            CL_ITYPE: w = {imm[11:0], rs1, f3, rd, 7'b0010011};
            CL_JAL:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            default:  w = NOP_WORD;
        endcase
        return w;
    endfunction

    // Stage p0: handshake and combinational encode of the offered request.
    assign req_ready   = readyQ && (state == IDLE);
    assign vld_p0      = req_valid && req_ready;
    assign legal_p0    = isLegal(req_class, req_imm[0]);
    assign encWord_p0  = encodeWord(req_class, req_rd, req_rs1, req_rs2,
                                    req_funct3, req_funct7, req_imm[20:0]);
    assign unusedImmHi = ^req_imm[31:21];

    // Stage p1: the registered word is presented to memory while in WRITE.
    assign mem_we = (state == WRITE);

    // State register. The asynchronous reset aborts a pending write immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic. A legal accept starts a write, and the write ends on ack.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (vld_p0 && legal_p0) nextState = WRITE;
            WRITE:   if (mem_ack)            nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Holds req_ready low during the reset cycle, then opens the request port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) readyQ <= 1'b0;
        else        readyQ <= 1'b1;
    end

    // Captures the encoded word, advances the address and count on ack, and keeps err sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wdata <= '0;
            mem_addr  <= AW'(RESET_ADDR);
            count     <= '0;
            err       <= 1'b0;
        end else begin
            if (vld_p0 && legal_p0)
                mem_wdata <= encWord_p0;
            if (state == WRITE && mem_ack) begin
                mem_addr <= mem_addr + AW'(4);
                count    <= count + 16'd1;
            end
            // A new error wins over a clear in the same cycle.
            if (vld_p0 && !legal_p0) err <= 1'b1;
            else if (err_clr)        err <= 1'b0;
        end
    end

endmodule
